fir_seq_ctrl: RTL and testbench

- Sequencer for the band FIR filters in the equalizer datapath.
- Accepts a sample strobe from the codec interface and writes each sample into a circular sample queue RAM.
- Once the queue holds TAPS samples, it walks read addresses oldest-to-newest and asserts `sequencing` to the band FIRs for exactly TAPS cycles.
- Flags samples that arrive while a convolution is still in progress.

---
 rtl/eq_pkg.sv | 11 +
 rtl/fir_seq_ctrl.sv | 81 ++++++++
 tb/tb_fir_seq_ctrl.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/eq_pkg.sv
// eq_pkg: shared parameters and state type for the equalizer FIR sequencer
//   DEF_TAPS   - coefficients per band FIR (one convolution pass length)
//   DEF_ADDR_W - sample queue address width
//   DEF_DEPTH  - sample queue entries (2**DEF_ADDR_W)
//   seq_state_t - sequencer states IDLE, PRIME, RUN, DONE
package eq_pkg;
    localparam int DEF_TAPS   = 1021;
    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DEPTH  = 1024;
    typedef enum logic [1:0] {IDLE, PRIME, RUN, DONE} seq_state_t;
endpackage

// File: rtl/fir_seq_ctrl.sv
// fir_seq_ctrl: writes codec samples into a circular queue and, once TAPS samples
// are held, walks the last TAPS entries oldest-to-newest for the band FIRs.
//   clk, rst_n  - clock, asynchronous active-low reset
//   smpl_vld    - one-cycle strobe, sample present on queue write data
//   clr_ovr     - clears the sticky overrun flag
//   wrt_smpl    - queue write enable (smpl_vld while idle)
//   waddr       - queue write address
//   raddr       - queue read address (RAM has one cycle read latency)
//   sequencing  - FIR accumulate enable, high TAPS consecutive cycles
//   seq_done    - one-cycle pulse when the FIR result is final
//   queue_full  - at least TAPS samples written since reset
//   busy        - a pass is in progress
//   overrun     - sticky, a sample arrived mid-pass and was dropped
module fir_seq_ctrl
    import eq_pkg::*;
#(
    parameter int TAPS   = DEF_TAPS,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              smpl_vld,
    input  logic              clr_ovr,
    output logic              wrt_smpl,
    output logic [ADDR_W-1:0] waddr,
    output logic [ADDR_W-1:0] raddr,
    output logic              sequencing,
    output logic              seq_done,
    output logic              queue_full,
    output logic              busy,
    output logic              overrun
);
    localparam int CW = $clog2(TAPS + 1);
    // adding DEPTH-(TAPS-1) is the same as subtracting TAPS-1 modulo DEPTH
    localparam logic [ADDR_W-1:0] BACK = ADDR_W'(DEPTH - (TAPS - 1));
    seq_state_t state, nxt;
    logic [ADDR_W-1:0] wptr;
    logic [CW-1:0] fill, tap_cnt;
    logic accept, pass_go, last;
    assign accept     = (state == IDLE) && smpl_vld;
    assign pass_go    = accept && (fill >= CW'(TAPS - 1));
    assign last       = (tap_cnt == CW'(TAPS - 1));
    assign wrt_smpl   = accept;
    assign waddr      = wptr;
    assign busy       = (state != IDLE);
    assign seq_done   = (state == DONE);
    assign queue_full = (fill == CW'(TAPS));
    always_comb begin
        nxt = state;
        nxt = (state == IDLE)  ? (pass_go ? PRIME : IDLE) :
              (state == PRIME) ? RUN :
              (state == RUN)   ? (last ? DONE : RUN) : IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            wptr       <= '0;
            raddr      <= '0;
            fill       <= '0;
            tap_cnt    <= '0;
            sequencing <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state <= nxt;
            if (accept) begin
                wptr <= wptr + 1'b1;
                fill <= queue_full ? fill : fill + 1'b1;
            end
            if (pass_go)
                raddr <= wptr + BACK;
            else if (state == PRIME || state == RUN)
                raddr <= raddr + 1'b1;
            tap_cnt <= (state == RUN) ? tap_cnt + 1'b1 : '0;
            // registered so the first RAM word lines up with the first enable
            sequencing <= (nxt == RUN);
            // a drop in the same cycle as a clear must still be reported
            overrun <= (smpl_vld && state != IDLE) ? 1'b1 : (clr_ovr ? 1'b0 : overrun);
        end
    end
endmodule

// File: tb/tb_fir_seq_ctrl.sv
module tb_fir_seq_ctrl;
    localparam int T0 = 1021, A0 = 10, D0 = 1024;
    localparam int T1 = 8, A1 = 4, D1 = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0, vld = 1'b0, clr = 1'b0;
    logic w0, sq0, dn0, qf0, by0, ov0;
    logic [A0-1:0] wa0, ra0;

    logic rst1_n = 1'b0, vld1 = 1'b0, clr1 = 1'b0;
    logic w1, sq1, dn1, qf1, by1, ov1;
    logic [A1-1:0] wa1, ra1;

    fir_seq_ctrl #(.TAPS(T0), .ADDR_W(A0), .DEPTH(D0)) dut (
        .clk(clk), .rst_n(rst_n), .smpl_vld(vld), .clr_ovr(clr),
        .wrt_smpl(w0), .waddr(wa0), .raddr(ra0), .sequencing(sq0),
        .seq_done(dn0), .queue_full(qf0), .busy(by0), .overrun(ov0));

    fir_seq_ctrl #(.TAPS(T1), .ADDR_W(A1), .DEPTH(D1)) dut_small (
        .clk(clk), .rst_n(rst1_n), .smpl_vld(vld1), .clr_ovr(clr1),
        .wrt_smpl(w1), .waddr(wa1), .raddr(ra1), .sequencing(sq1),
        .seq_done(dn1), .queue_full(qf1), .busy(by1), .overrun(ov1));

    int checks = 0, failures = 0;
    int waddr_q[$];
    int start_q[$];
    int wp = 0, fill = 0;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic flag(string name);
        checks++;
        failures++;
        $display("FAIL %s actual=unexpected required=none", name);
    endtask

    // one accepted sample on the large instance; expectations queued for the monitor
    task automatic send0();
        @(posedge clk); #1;
        vld = 1'b1;
        waddr_q.push_back(wp);
        if (fill + 1 >= T0) start_q.push_back(((wp - (T0 - 1)) % D0 + D0) % D0);
        wp = (wp + 1) % D0;
        fill = (fill + 1 > T0) ? T0 : fill + 1;
        @(posedge clk); #1;
        vld = 1'b0;
    endtask

    task automatic wait_done0(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!dn0 && n < T0 + 20);
        if (!dn0) flag("done_timeout");
    endtask

    // monitor: pops queued writes and pass start addresses as the DUT presents them
    int st = 0, k = 0, errs = 0;
    logic active = 1'b0, prev_by = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            active = 1'b0;
            k = 0;
            prev_by = 1'b0;
        end else begin
            if (w0) begin
                if (waddr_q.size() == 0) flag("unexpected_write");
                else chk("waddr", int'(wa0), waddr_q.pop_front());
            end
            if (by0 && !prev_by) begin
                if (start_q.size() == 0) flag("unexpected_pass");
                else begin
                    st = start_q.pop_front();
                    chk("prime_raddr", int'(ra0), st);
                    chk("prime_seq_low", int'(sq0), 0);
                    active = 1'b1;
                    k = 0;
                    errs = 0;
                end
            end
            if (sq0) begin
                if (!active) flag("seq_without_pass");
                if (int'(ra0) != (st + 1 + k) % D0) errs++;
                k++;
            end
            if (dn0) begin
                if (!active) flag("done_without_pass");
                chk("seq_cycles", k, T0);
                chk("raddr_walk_errs", errs, 0);
                chk("done_seq_low", int'(sq0), 0);
                active = 1'b0;
                k = 0;
            end
            prev_by = by0;
        end
    end

    task automatic run_main();
        int n;
        #12;
        chk("rst_seq", int'(sq0), 0);
        chk("rst_busy", int'(by0), 0);
        chk("rst_full", int'(qf0), 0);
        chk("rst_ovr", int'(ov0), 0);
        chk("rst_done", int'(dn0), 0);
        chk("rst_raddr", int'(ra0), 0);
        chk("rst_waddr", int'(wa0), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (1020) send0();
        @(negedge clk);
        chk("t1_full", int'(qf0), 0);
        chk("t1_busy", int'(by0), 0);
        chk("t1_seq", int'(sq0), 0);
        chk("t1_pending_writes", waddr_q.size(), 0);
        send0();
        wait_done0(n);
        chk("t2_latency", n, T0 + 2);
        @(negedge clk);
        chk("t2_full", int'(qf0), 1);
        chk("t2_done_single", int'(dn0), 0);
        chk("t2_busy", int'(by0), 0);
        repeat (8) begin
            send0();
            wait_done0(n);
        end
        chk("t3_waddr_next", int'(wa0), 5);
        send0();
        @(negedge clk);
        chk("t3_prime_raddr", int'(ra0), 9);
        wait_done0(n);
        send0();
        repeat (10) @(posedge clk);
        #1;
        vld = 1'b1;
        @(negedge clk);
        chk("t4_drop_wrt", int'(w0), 0);
        chk("t4_wptr_hold", int'(wa0), wp);
        @(posedge clk); #1;
        vld = 1'b0;
        @(negedge clk);
        chk("t4_ovr_set", int'(ov0), 1);
        wait_done0(n);
        chk("t4_ovr_sticky", int'(ov0), 1);
        @(posedge clk); #1;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        @(negedge clk);
        chk("t4_ovr_clr", int'(ov0), 0);
        send0();
        repeat (5) @(posedge clk);
        #1;
        vld = 1'b1;
        clr = 1'b1;
        @(posedge clk); #1;
        vld = 1'b0;
        clr = 1'b0;
        @(negedge clk);
        chk("t4_set_wins", int'(ov0), 1);
        wait_done0(n);
        send0();
        repeat (20) @(posedge clk);
        #3;
        chk("t5_seq_pre", int'(sq0), 1);
        rst_n = 1'b0;
        #1;
        chk("t5_seq", int'(sq0), 0);
        chk("t5_busy", int'(by0), 0);
        chk("t5_full", int'(qf0), 0);
        chk("t5_ovr", int'(ov0), 0);
        chk("t5_waddr", int'(wa0), 0);
        start_q.delete();
        waddr_q.delete();
        wp = 0;
        fill = 0;
        repeat (3) @(negedge clk);
        chk("t5_no_done", int'(dn0), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        send0();
        repeat (5) @(negedge clk);
        chk("t5_refill_idle", int'(by0), 0);
        chk("t5_refill_seq", int'(sq0), 0);
    endtask

    task automatic run_small();
        int n, sc, wp1;
        wp1 = 0;
        repeat (3) @(posedge clk);
        #1;
        rst1_n = 1'b1;
        for (int i = 0; i < T1 - 1; i++) begin
            @(posedge clk); #1;
            vld1 = 1'b1;
            @(negedge clk);
            chk("s_fill_waddr", int'(wa1), wp1);
            wp1 = (wp1 + 1) % D1;
            @(posedge clk); #1;
            vld1 = 1'b0;
        end
        for (int p = 0; p < 4; p++) begin
            @(posedge clk); #1;
            vld1 = 1'b1;
            @(negedge clk);
            chk("s_wrt", int'(w1), 1);
            chk("s_waddr", int'(wa1), wp1);
            wp1 = (wp1 + 1) % D1;
            @(posedge clk); #1;
            vld1 = 1'b0;
            n = 0;
            sc = 0;
            do begin
                @(negedge clk);
                n++;
                if (sq1) sc++;
            end while (!dn1 && n < T1 + 20);
            chk("s_latency", n, T1 + 2);
            chk("s_seq_cycles", sc, T1);
        end
        @(negedge clk);
        chk("s_ovr", int'(ov1), 0);
        chk("s_full", int'(qf1), 1);
    endtask

    initial begin
        fork
            run_main();
            run_small();
        join
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
